nibble_alu: RTL and testbench

NIBBLE_ALU -- requirements
Module: nibble_alu

---
 rtl/nibble_alu_pkg.sv | 52 +++++
 rtl/nibble_alu_slice.sv | 42 ++++
 rtl/nibble_alu.sv | 210 +++++++++++++++++++++
 tb/tb_nibble_alu.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_alu_pkg.sv
// Shared types for the nibble-serial ALU: op codes, FSM states, flag bit positions.
// Latency: n/a (package).
// Backpressure: n/a (package).
// The ADJ state exists only when NIBBLE_ALU_DAA_EN is defined.
package nibble_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_ADC = 4'h1,
        OP_SUB = 4'h2,
        OP_SBC = 4'h3,
        OP_AND = 4'h4,
        OP_XOR = 4'h5,
        OP_OR  = 4'h6,
        OP_CP  = 4'h7,
        OP_INC = 4'h8,
        OP_DEC = 4'h9,
        OP_DAA = 4'hA
    } op_e;

`ifdef NIBBLE_ALU_DAA_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_ADJ  = 2'd2,
        S_DONE = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd3
    } state_e;
`endif

    // Bit positions inside the {Z,N,H,C} flag vector.
    localparam int FLAG_C = 0;
    localparam int FLAG_H = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 3;

    // Carry/borrow fed into nibble 0. INC/DEC reuse the chain with a forced
    // +/-1 so the same slice handles them.
    function automatic logic init_carry(input logic [3:0] op, input logic [3:0] flags);
        case (op)
            OP_ADC, OP_SBC: return flags[FLAG_C];
            OP_INC, OP_DEC: return 1'b1;
            default:        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/nibble_alu_slice.sv
// 4-bit add/subtract/logic slice, one nibble of the serial ALU datapath.
// Latency: combinational.
// Backpressure: none (pure function of inputs).
// Ports: op (op code), a4/b4 (operand nibbles), cin (carry or borrow in),
//        r4 (result nibble), cout (carry or borrow out; 0 for logic ops).
module nibble_alu_slice
    import nibble_alu_pkg::*;
(
    input  logic [3:0] op,
    input  logic [3:0] a4,
    input  logic [3:0] b4,
    input  logic       cin,
    output logic [3:0] r4,
    output logic       cout
);

    logic [4:0] sum;
    logic [4:0] diff;
    logic [4:0] inc;
    logic [4:0] dec;

    always_comb begin
        sum  = {1'b0, a4} + {1'b0, b4} + {4'b0000, cin};
        // Bit 4 of a 5-bit difference is the borrow out.
        diff = {1'b0, a4} - {1'b0, b4} - {4'b0000, cin};
        inc  = {1'b0, b4} + {4'b0000, cin};
        dec  = {1'b0, b4} - {4'b0000, cin};
        r4   = a4;
        cout = 1'b0;
        case (op)
            OP_ADD, OP_ADC:        {cout, r4} = sum;
            OP_SUB, OP_SBC, OP_CP: {cout, r4} = diff;
            OP_AND:                r4 = a4 & b4;
            OP_XOR:                r4 = a4 ^ b4;
            OP_OR:                 r4 = a4 | b4;
            OP_INC:                {cout, r4} = inc;
            OP_DEC:                {cout, r4} = dec;
            default:               ;
        endcase
    end

endmodule

// File: rtl/nibble_alu.sv
// Nibble-serial ALU: one 4-bit slice per cycle, LSB first, flags in {Z,N,H,C} order.
// Latency: out_valid from edge T+NIBBLES+1 after accept at T (T+2 for DAA).
// Backpressure: result/flag_out held with out_valid until out_ready; in_ready low while busy.
// Ports: clk, reset (sync, active high); in_valid/in_ready request handshake with
//        op, a, b, flag_in; out_valid/out_ready result handshake with result, flag_out.
// Optional: define NIBBLE_ALU_DAA_EN to enable op A (DAA) via the ADJ state.
module nibble_alu
    import nibble_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       flag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flag_out
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    // H is the carry out of the second-highest nibble; at WIDTH=4 it
    // collapses onto the single nibble, making H equal to C.
    localparam int H_IDX   = (NIBBLES > 1) ? NIBBLES - 2 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);
    localparam logic [CNT_W-1:0] CNT_H    = CNT_W'(H_IDX);

    state_e           state;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       flag_q;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             c_q;
    logic             h_q;

    logic [3:0]       s_r4;
    logic             s_cout;
    logic [WIDTH-1:0] fin_result;
    logic [3:0]       fin_flags;
    logic             z_acc;

    assign in_ready = (state == S_IDLE);

    nibble_alu_slice u_slice (
        .op   (op_q),
        .a4   (4'(a_q >> {cnt, 2'b00})),
        .b4   (4'(b_q >> {cnt, 2'b00})),
        .cin  (c_q),
        .r4   (s_r4),
        .cout (s_cout)
    );

`ifdef NIBBLE_ALU_DAA_EN
    // Decimal adjust of the low byte; upper bits pass through untouched.
    logic [31:0]      a_ext;
    logic [7:0]       daa_lo;
    logic             daa_c;
    logic [WIDTH-1:0] daa_res;

    always_comb begin
        a_ext  = 32'(a_q);
        daa_lo = a_ext[7:0];
        daa_c  = flag_q[FLAG_C];
        if (!flag_q[FLAG_N]) begin
            if (flag_q[FLAG_C] || (a_ext[7:0] > 8'h99)) begin
                daa_lo = daa_lo + 8'h60;
                daa_c  = 1'b1;
            end
            if (flag_q[FLAG_H] || (a_ext[3:0] > 4'd9)) begin
                daa_lo = daa_lo + 8'h06;
            end
        end else begin
            if (flag_q[FLAG_C]) begin
                daa_lo = daa_lo - 8'h60;
            end
            if (flag_q[FLAG_H]) begin
                daa_lo = daa_lo - 8'h06;
            end
        end
        daa_res = WIDTH'({a_ext[31:8], daa_lo});
    end
`endif

    // Final result/flag selection from the completed accumulator.
    always_comb begin
        z_acc      = (acc == '0);
        fin_result = acc;
        fin_flags  = 4'b0000;
        case (op_q)
            OP_ADD, OP_ADC: begin
                fin_flags[FLAG_C] = c_q;
                fin_flags[FLAG_H] = h_q;
                fin_flags[FLAG_Z] = z_acc;
            end
            OP_SUB, OP_SBC, OP_CP: begin
                // CP keeps a as the result but reports flags of a-b.
                if (op_q == OP_CP) begin
                    fin_result = a_q;
                end
                fin_flags[FLAG_C] = c_q;
                fin_flags[FLAG_H] = h_q;
                fin_flags[FLAG_N] = 1'b1;
                fin_flags[FLAG_Z] = z_acc;
            end
            OP_AND: begin
                fin_flags[FLAG_H] = 1'b1;
                fin_flags[FLAG_Z] = z_acc;
            end
            OP_XOR, OP_OR: begin
                fin_flags[FLAG_Z] = z_acc;
            end
            OP_INC, OP_DEC: begin
                fin_flags[FLAG_C] = flag_q[FLAG_C];
                fin_flags[FLAG_H] = h_q;
                fin_flags[FLAG_N] = (op_q == OP_DEC);
                fin_flags[FLAG_Z] = z_acc;
            end
`ifdef NIBBLE_ALU_DAA_EN
            OP_DAA: begin
                fin_flags[FLAG_C] = c_q;
                fin_flags[FLAG_N] = flag_q[FLAG_N];
                fin_flags[FLAG_Z] = z_acc;
            end
`endif
            default: begin
                fin_result = a_q;
                fin_flags  = flag_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            op_q      <= 4'h0;
            a_q       <= '0;
            b_q       <= '0;
            flag_q    <= 4'h0;
            acc       <= '0;
            cnt       <= '0;
            c_q       <= 1'b0;
            h_q       <= 1'b0;
            result    <= '0;
            flag_out  <= 4'h0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q   <= op;
                        a_q    <= a;
                        b_q    <= b;
                        flag_q <= flag_in;
                        acc    <= '0;
                        cnt    <= '0;
                        c_q    <= init_carry(op, flag_in);
                        h_q    <= 1'b0;
`ifdef NIBBLE_ALU_DAA_EN
                        state  <= (op == OP_DAA) ? S_ADJ : S_CALC;
`else
                        state  <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    // acc was cleared on accept, so OR-ing in each nibble builds the word.
                    acc <= acc | (WIDTH'(s_r4) << {cnt, 2'b00});
                    c_q <= s_cout;
                    if (cnt == CNT_H) begin
                        h_q <= s_cout;
                    end
                    if (cnt == CNT_LAST) begin
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef NIBBLE_ALU_DAA_EN
                S_ADJ: begin
                    acc   <= daa_res;
                    c_q   <= daa_c;
                    state <= S_DONE;
                end
`endif
                S_DONE: begin
                    // First DONE cycle registers the outputs; out_valid then
                    // holds them until the consumer takes the result.
                    if (!out_valid) begin
                        result    <= fin_result;
                        flag_out  <= fin_flags;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_alu.sv
// Randomised and directed bench for nibble_alu at WIDTH=8 against an arithmetic reference model.
// Latency: checks out_valid arrives NIBBLES+1 cycles after accept (2 for DAA when enabled).
// Backpressure: holds out_ready low for several cycles and checks stability and release.
module tb_nibble_alu;

    localparam int W    = 8;
    localparam int NIB  = W / 4;
    localparam int MOD  = 1 << W;
    localparam int HB   = (W > 4) ? W - 4 : W;
    localparam int HMOD = 1 << HB;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   flag_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flag_out;

    int           tests_run;
    int           tests_failed;
    logic [7:0]   got_r;
    logic [3:0]   got_f;

    nibble_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .flag_in   (flag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_out  (flag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: whole-word integer arithmetic; flags returned as {Z,N,H,C}.
    function automatic void model(input logic [3:0] o, input logic [7:0] xa, input logic [7:0] xb,
                                  input logic [3:0] xf, output logic [7:0] r, output logic [3:0] f);
        int   ai;
        int   bi;
        int   ci;
        int   full;
        int   lo;
        logic c;
        logic h;
        logic n;
        logic rsv;
        logic [7:0] arith;
        ai = int'(xa);
        bi = int'(xb);
        ci = 0;
        full = 0;
        lo = 0;
        c = 1'b0;
        h = 1'b0;
        n = 1'b0;
        rsv = 1'b0;
        case (o)
            4'h0, 4'h1: begin
                ci   = (o == 4'h1) ? int'(xf[0]) : 0;
                full = ai + bi + ci;
                lo   = (ai % HMOD) + (bi % HMOD) + ci;
                c    = (full >= MOD);
                h    = (lo >= HMOD);
            end
            4'h2, 4'h3, 4'h7: begin
                ci   = (o == 4'h3) ? int'(xf[0]) : 0;
                full = ai - bi - ci;
                lo   = (ai % HMOD) - (bi % HMOD) - ci;
                c    = (full < 0);
                h    = (lo < 0);
                n    = 1'b1;
            end
            4'h4: begin
                full = ai & bi;
                h    = 1'b1;
            end
            4'h5: full = ai ^ bi;
            4'h6: full = ai | bi;
            4'h8: begin
                full = bi + 1;
                h    = ((bi % HMOD) + 1 >= HMOD);
                c    = xf[0];
            end
            4'h9: begin
                full = bi - 1;
                h    = ((bi % HMOD) - 1 < 0);
                c    = xf[0];
                n    = 1'b1;
            end
`ifdef NIBBLE_ALU_DAA_EN
            4'hA: begin
                n    = xf[2];
                c    = xf[0];
                full = ai;
                if (!n) begin
                    if (xf[0] || ai > 'h99) begin
                        full = full + 'h60;
                        c    = 1'b1;
                    end
                    if (xf[1] || (ai % 16) > 9) full = full + 6;
                end else begin
                    if (xf[0]) full = full - 'h60;
                    if (xf[1]) full = full - 6;
                end
            end
`endif
            default: rsv = 1'b1;
        endcase
        arith = 8'(full);
        if (rsv) begin
            r = xa;
            f = xf;
        end else begin
            r = (o == 4'h7) ? xa : arith;
            f = {(arith == 8'h00), n, h, c};
        end
    endfunction

    // One full transaction: accept, wait for result, hold under backpressure, release.
    task automatic run_op(input logic [3:0] o, input logic [7:0] xa, input logic [7:0] xb,
                          input logic [3:0] xf, input int hold,
                          output logic [7:0] rr, output logic [3:0] rf);
        logic [7:0] er;
        logic [3:0] ef;
        int lat;
        int elat;
        model(o, xa, xb, xf, er, ef);
        elat = NIB + 1;
`ifdef NIBBLE_ALU_DAA_EN
        if (o == 4'hA) elat = 2;
`endif
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op = o;
        a = xa;
        b = xb;
        flag_in = xf;
        @(posedge clk);
        #1;
        // Scramble inputs so any failure to latch shows up in the result.
        in_valid = 1'b0;
        op = 4'($urandom);
        a = 8'($urandom);
        b = 8'($urandom);
        flag_in = 4'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            check("in_ready_busy", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(elat));
        rr = result;
        rf = flag_out;
        check("result", 32'(result), 32'(er));
        check("flags", 32'(flag_out), 32'(ef));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_result", 32'(result), 32'(er));
            check("hold_flags", 32'(flag_out), 32'(ef));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset = 1'b1;
        in_valid = 1'b0;
        op = 4'h0;
        a = '0;
        b = '0;
        flag_in = 4'h0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'(flag_out), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // 0x3A + 0xC6 wraps to zero with both carries.
        run_op(4'h0, 8'h3A, 8'hC6, 4'h0, 0, got_r, got_f);
        check("add_3a_c6_res", 32'(got_r), 32'h00);
        check("add_3a_c6_flg", 32'(got_f), 32'b1011);
        // 0xFF + 1 wraps modulo 256.
        run_op(4'h0, 8'hFF, 8'h01, 4'h0, 1, got_r, got_f);
        check("add_ff_1_res", 32'(got_r), 32'h00);
        check("add_ff_1_c", 32'(got_f[0]), 32'd1);
        // SBC with carry-in, then CP on the same operands.
        run_op(4'h3, 8'h10, 8'h01, 4'b0001, 0, got_r, got_f);
        check("sbc_res", 32'(got_r), 32'h0E);
        check("sbc_flg", 32'(got_f), 32'b0110);
        run_op(4'h7, 8'h10, 8'h01, 4'b0001, 0, got_r, got_f);
        check("cp_res", 32'(got_r), 32'h10);
        check("cp_flg", 32'(got_f), 32'b0110);
        // Long backpressure.
        run_op(4'h5, 8'h5A, 8'h0F, 4'h0, 5, got_r, got_f);
        check("xor_bp_res", 32'(got_r), 32'h55);
        // BCD adjust after a binary add.
        run_op(4'h0, 8'h45, 8'h38, 4'h0, 0, got_r, got_f);
        check("bcd_add_res", 32'(got_r), 32'h7D);
        check("bcd_add_h", 32'(got_f[1]), 32'd0);
`ifdef NIBBLE_ALU_DAA_EN
        run_op(4'hA, got_r, 8'h00, got_f, 0, got_r, got_f);
        check("daa_res", 32'(got_r), 32'h83);
        check("daa_c", 32'(got_f[0]), 32'd0);
`else
        run_op(4'hA, 8'h7D, 8'h00, 4'b0101, 0, got_r, got_f);
        check("op_a_rsv_res", 32'(got_r), 32'h7D);
        check("op_a_rsv_flg", 32'(got_f), 32'b0101);
`endif

        // Reset during the second CALC cycle discards the request.
        @(negedge clk);
        in_valid = 1'b1;
        op = 4'h0;
        a = 8'h12;
        b = 8'h34;
        flag_in = 4'h0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midcalc_rst_result", 32'(result), 32'd0);
        check("midcalc_rst_flags", 32'(flag_out), 32'd0);
        check("midcalc_rst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("midcalc_rst_no_valid", 32'(out_valid), 32'd0);
        end
        run_op(4'h1, 8'h0F, 8'h00, 4'b0001, 0, got_r, got_f);
        check("after_rst_adc_res", 32'(got_r), 32'h10);

        // Reset while waiting in DONE.
        @(negedge clk);
        in_valid = 1'b1;
        op = 4'h4;
        a = 8'hF0;
        b = 8'h3C;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("done_valid_before_rst", 32'(out_valid), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("done_rst_valid", 32'(out_valid), 32'd0);
        check("done_rst_result", 32'(result), 32'd0);

        // Random traffic over all sixteen op codes.
        for (int n = 0; n < 150; n++) begin
            run_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 4'($urandom),
                   int'($urandom_range(0, 2)), got_r, got_f);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
